// File: rtl/fft_pkg.sv
// Shared types for the FFT framing path: sample width, packed complex word, read-FSM states.
package fft_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } fb_state_t;

endpackage

// File: rtl/fft_window_4.sv
// Periodic 4-point Hann window using shifts only: gains 0, 1/2, 1, 1/2. Combinational.
// Used only in builds that define FFT_WINDOW_EN. The halving floors toward negative infinity.
module fft_window_4 #(
  parameter int SAMPLE_W = fft_pkg::SAMPLE_W
) (
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [1:0]          idx,
  output logic [SAMPLE_W-1:0] sample_out
);

  always_comb begin
    sample_out = sample_in;
    case (idx)
      2'd0:       sample_out = '0;
      2'd1, 2'd3: sample_out = {sample_in[SAMPLE_W-1], sample_in[SAMPLE_W-1:1]};
      default:    sample_out = sample_in;
    endcase
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong 4-sample framer for the FFT core: launch 1 cycle after the 4th sample, bank held until done or timeout.
// sample_ready drops only while both banks hold frames. FFT_WINDOW_EN applies a Hann window before storage.
module fft_frame_buffer #(
  parameter int SAMPLE_W       = fft_pkg::SAMPLE_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic [2*SAMPLE_W-1:0] fft_in0,
  output logic [2*SAMPLE_W-1:0] fft_in1,
  output logic [2*SAMPLE_W-1:0] fft_in2,
  output logic [2*SAMPLE_W-1:0] fft_in3,
  output logic                  fft_start,
  input  logic                  fft_done,
  output logic                  fft_timeout
);
  import fft_pkg::*;

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  fb_state_t                      state_q, state_d;
  logic [SAMPLE_W-1:0]            bank_q [2][4];
  logic [SAMPLE_W-1:0]            bank_d [2][4];
  logic [1:0]                     full_q, full_d;
  logic                           wr_bank_q, wr_bank_d;
  logic                           rd_bank_q, rd_bank_d;
  logic [1:0]                     wr_idx_q, wr_idx_d;
  logic                           done_q, done_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           timeout_q, timeout_d;
  logic [3:0][2*SAMPLE_W-1:0]     fft_in_q, fft_in_d;

  logic [SAMPLE_W-1:0]            wr_sample;
  logic                           accept;
  logic                           done_edge;
  logic                           rel_bank;

`ifdef FFT_WINDOW_EN
  fft_window_4 #(.SAMPLE_W(SAMPLE_W)) u_window (
    .sample_in  (sample_in),
    .idx        (wr_idx_q),
    .sample_out (wr_sample)
  );
`else
  assign wr_sample = sample_in;
`endif

  assign sample_ready = !full_q[wr_bank_q];
  assign accept       = sample_valid && sample_ready;
  assign done_edge    = fft_done && !done_q;

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    done_d    = fft_done;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    fft_in_d  = fft_in_q;
    rel_bank  = 1'b0;

    // Write side: a bank never accepts samples while full, so it cannot collide with the read side.
    if (accept) begin
      bank_d[wr_bank_q][wr_idx_q] = wr_sample;
      wr_idx_d = wr_idx_q + 2'd1;
      if (wr_idx_q == 2'd3) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d     = START;
          fft_in_d[0] = {bank_q[rd_bank_q][0], {SAMPLE_W{1'b0}}};
          fft_in_d[1] = {bank_q[rd_bank_q][1], {SAMPLE_W{1'b0}}};
          fft_in_d[2] = {bank_q[rd_bank_q][2], {SAMPLE_W{1'b0}}};
          fft_in_d[3] = {bank_q[rd_bank_q][3], {SAMPLE_W{1'b0}}};
        end
      end
      START: begin
        state_d = BUSY;
        cnt_d   = '0;
      end
      BUSY: begin
        if (done_edge) begin
          rel_bank = 1'b1;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rel_bank  = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rel_bank) begin
      state_d           = IDLE;
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 4; k++) begin
          bank_q[b][k] <= '0;
        end
      end
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      fft_in_q  <= '0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      fft_in_q  <= fft_in_d;
    end
  end

  assign fft_start   = (state_q == START);
  assign fft_timeout = timeout_q;
  assign fft_in0     = fft_in_q[0];
  assign fft_in1     = fft_in_q[1];
  assign fft_in2     = fft_in_q[2];
  assign fft_in3     = fft_in_q[3];

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench: dut_a (no timeout) covers framing, backpressure, stale done and reset; dut_t covers timeout 8.
module tb_fft_frame_buffer;
  import fft_pkg::*;

`ifdef FFT_WINDOW_EN
  localparam bit WIN = 1'b1;
`else
  localparam bit WIN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_rst_n, a_vld, a_rdy, a_start, a_done, a_to;
  logic [15:0] a_in;
  logic [31:0] a_w0, a_w1, a_w2, a_w3;
  logic        t_rst_n, t_vld, t_rdy, t_start, t_done, t_to;
  logic [15:0] t_in;
  logic [31:0] t_w0, t_w1, t_w2, t_w3;

  fft_frame_buffer #(.SAMPLE_W(16), .TIMEOUT_CYCLES(0)) dut_a (
    .clk(clk), .reset(a_rst_n), .sample_in(a_in), .sample_valid(a_vld), .sample_ready(a_rdy),
    .fft_in0(a_w0), .fft_in1(a_w1), .fft_in2(a_w2), .fft_in3(a_w3),
    .fft_start(a_start), .fft_done(a_done), .fft_timeout(a_to)
  );

  fft_frame_buffer #(.SAMPLE_W(16), .TIMEOUT_CYCLES(8)) dut_t (
    .clk(clk), .reset(t_rst_n), .sample_in(t_in), .sample_valid(t_vld), .sample_ready(t_rdy),
    .fft_in0(t_w0), .fft_in1(t_w1), .fft_in2(t_w2), .fft_in3(t_w3),
    .fft_start(t_start), .fft_done(t_done), .fft_timeout(t_to)
  );

  typedef struct packed {
    logic [3:0][31:0] w;
    logic [31:0]      cyc;
  } frame_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  sig;
    logic [31:0] val;
  } point_t;

  frame_t sb_a[$];
  frame_t sb_t[$];
  point_t pts[$];
  int     checks = 0;
  int     errors = 0;
  bit     end_req = 1'b0;
  bit     end_done = 1'b0;
  int     a_sent = 0;
  frame_t mf;
  point_t mp;

  function automatic logic [15:0] win(input logic [15:0] x, input int idx);
    if (!WIN) return x;
    if (idx == 0) return 16'h0000;
    if (idx == 2) return x;
    return 16'($signed(x) >>> 1);
  endfunction

  function automatic frame_t mk(input logic [15:0] s0, s1, s2, s3, input logic [31:0] c, input bit apply);
    logic [3:0][15:0] s;
    complex_t cw;
    frame_t f;
    s = {s3, s2, s1, s0};
    for (int k = 0; k < 4; k++) begin
      cw.re = apply ? win(s[k], k) : s[k];
      cw.im = '0;
      f.w[k] = cw;
    end
    f.cyc = c;
    return f;
  endfunction

  function automatic logic [31:0] sig_val(input logic [3:0] s);
    case (s)
      4'd0: return {31'd0, a_rdy};
      4'd1: return {31'd0, a_to};
      4'd2: return {31'd0, a_start};
      4'd3: return a_w0;
      4'd4: return a_w1;
      4'd5: return a_w2;
      4'd6: return a_w3;
      4'd7: return {31'd0, t_rdy};
      4'd8: return {31'd0, t_to};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic string sig_name(input logic [3:0] s);
    case (s)
      4'd0: return "a_sample_ready";
      4'd1: return "a_fft_timeout";
      4'd2: return "a_fft_start";
      4'd3: return "a_fft_in0";
      4'd4: return "a_fft_in1";
      4'd5: return "a_fft_in2";
      4'd6: return "a_fft_in3";
      4'd7: return "t_sample_ready";
      4'd8: return "t_fft_timeout";
      default: return "unknown";
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_frame(input string d, input frame_t f, input logic [3:0][31:0] act);
    for (int k = 0; k < 4; k++) cmp($sformatf("frame_%s_word%0d", d, k), act[k], f.w[k]);
    cmp($sformatf("frame_%s_launch_cycle", d), cyc, f.cyc);
  endtask

  // Monitor: launches are matched against frame queues, level checks against the point queue.
  always @(negedge clk) begin
    if (a_start) begin
      if (sb_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL launch_a: unexpected fft_start at cycle %0d", cyc);
      end else begin
        mf = sb_a.pop_front();
        cmp_frame("a", mf, {a_w3, a_w2, a_w1, a_w0});
      end
    end
    if (t_start) begin
      if (sb_t.size() == 0) begin
        checks++; errors++;
        $display("FAIL launch_t: unexpected fft_start at cycle %0d", cyc);
      end else begin
        mf = sb_t.pop_front();
        cmp_frame("t", mf, {t_w3, t_w2, t_w1, t_w0});
      end
    end
    for (int i = pts.size() - 1; i >= 0; i--) begin
      if (pts[i].cyc == cyc) begin
        mp = pts[i];
        pts.delete(i);
        cmp(sig_name(mp.sig), sig_val(mp.sig), mp.val);
      end
    end
    if (end_req && !end_done) begin
      end_done = 1'b1;
      foreach (sb_a[i]) begin
        checks++; errors++;
        $display("FAIL launch_a: frame due at cycle %0d never launched", sb_a[i].cyc);
      end
      foreach (sb_t[i]) begin
        checks++; errors++;
        $display("FAIL launch_t: frame due at cycle %0d never launched", sb_t[i].cyc);
      end
      foreach (pts[i]) begin
        checks++; errors++;
        $display("FAIL %s: check at cycle %0d never reached", sig_name(pts[i].sig), pts[i].cyc);
      end
    end
  end

  task automatic pt(input logic [31:0] c, input logic [3:0] s, input logic [31:0] v);
    point_t p;
    p.cyc = c; p.sig = s; p.val = v;
    pts.push_back(p);
  endtask

  task automatic wait_cyc(input logic [31:0] t);
    while (cyc < t) @(negedge clk);
  endtask

  // Offers one sample; e returns the edge number at which it was accepted.
  task automatic send(input bit d, input logic [15:0] x, output logic [31:0] e);
    logic r;
    e = 0;
    if (d) begin t_in = x; t_vld = 1'b1; end
    else   begin a_in = x; a_vld = 1'b1; end
    for (int i = 0; i < 400; i++) begin
      r = d ? t_rdy : a_rdy;
      e = cyc + 1;
      @(negedge clk);
      if (r) begin
        if (d) t_vld = 1'b0;
        else begin a_vld = 1'b0; a_sent++; end
        return;
      end
    end
    $display("FAIL send: sample %h to dut %0d never accepted", x, d);
    $fatal(1, "handshake stuck");
  endtask

  task automatic run_a();
    logic [31:0] e, c;
    // Basic frame, done returned 5 cycles after launch.
    send(0, 16'd100, e); send(0, 16'd200, e); send(0, 16'd300, e); send(0, 16'd400, e);
    if (WIN) sb_a.push_back(mk(16'd0, 16'd100, 16'd300, 16'd200, e + 1, 1'b0));
    else     sb_a.push_back(mk(16'd100, 16'd200, 16'd300, 16'd400, e + 1, 1'b0));
    pt(e + 2, 4'd2, 32'd0);
    wait_cyc(e + 5); a_done = 1'b1;
    wait_cyc(e + 8); a_done = 1'b0;

    // Backpressure: 9 samples, no done until both banks are full.
    a_sent = 0;
    c = 0;
    fork
      begin
        send(0, 16'd5, e); send(0, 16'hFFFD, e); send(0, 16'd7, e); send(0, 16'hFFF8, e);
        if (WIN) sb_a.push_back(mk(16'd0, 16'hFFFE, 16'd7, 16'hFFFC, e + 1, 1'b0));
        else     sb_a.push_back(mk(16'd5, 16'hFFFD, 16'd7, 16'hFFF8, e + 1, 1'b0));
        send(0, 16'd21, e); send(0, 16'd22, e); send(0, 16'd23, e); send(0, 16'd24, e);
        send(0, 16'd25, e);
      end
      begin
        while (a_sent < 8) @(negedge clk);
        c = cyc;
        pt(c + 1, 4'd0, 32'd0);
        pt(c + 5, 4'd0, 32'd0);
        wait_cyc(c + 6);
        a_done = 1'b1;
        pt(c + 7, 4'd0, 32'd1);
        sb_a.push_back(mk(16'd21, 16'd22, 16'd23, 16'd24, c + 8, 1'b1));
      end
    join
    a_done = 1'b0;
    wait_cyc(c + 10); a_done = 1'b1;

    // Stale done: held high across the next launch, must not release it.
    send(0, 16'd26, e); send(0, 16'd27, e); send(0, 16'd28, e);
    sb_a.push_back(mk(16'd25, 16'd26, 16'd27, 16'd28, e + 1, 1'b1));
    send(0, 16'd29, e); send(0, 16'd30, e); send(0, 16'd31, e); send(0, 16'd32, e);
    pt(e + 1, 4'd0, 32'd0);
    pt(e + 10, 4'd0, 32'd0);
    wait_cyc(e + 10); a_done = 1'b0;
    wait_cyc(e + 12); a_done = 1'b1;
    pt(e + 13, 4'd0, 32'd1);
    sb_a.push_back(mk(16'd29, 16'd30, 16'd31, 16'd32, e + 14, 1'b1));
    wait_cyc(e + 14); a_done = 1'b0;
    wait_cyc(e + 16); a_done = 1'b1;
    wait_cyc(e + 18); a_done = 1'b0;

    // Reset while BUSY with two samples pending in the other bank.
    send(0, 16'd40, e); send(0, 16'd41, e); send(0, 16'd42, e); send(0, 16'd43, e);
    sb_a.push_back(mk(16'd40, 16'd41, 16'd42, 16'd43, e + 1, 1'b1));
    send(0, 16'd44, e); send(0, 16'd45, e);
    c = cyc;
    pt(c + 1, 4'd0, 32'd1);
    for (int s = 1; s <= 6; s++) pt(c + 1, 4'(s), 32'd0);
    #2 a_rst_n = 1'b0;
    wait_cyc(c + 2);
    a_rst_n = 1'b1;
    send(0, 16'd50, e); send(0, 16'd51, e); send(0, 16'd52, e); send(0, 16'd53, e);
    sb_a.push_back(mk(16'd50, 16'd51, 16'd52, 16'd53, e + 1, 1'b1));
    wait_cyc(e + 3); a_done = 1'b1;
    wait_cyc(e + 5); a_done = 1'b0;
    wait_cyc(e + 8);
  endtask

  task automatic run_t();
    logic [31:0] e, e4;
    send(1, 16'd1000, e); send(1, 16'd1001, e); send(1, 16'd1002, e); send(1, 16'd1003, e);
    e4 = e;
    sb_t.push_back(mk(16'd1000, 16'd1001, 16'd1002, 16'd1003, e4 + 1, 1'b1));
    send(1, 16'd1004, e); send(1, 16'd1005, e); send(1, 16'd1006, e); send(1, 16'd1007, e);
    // BUSY entered at e4+2 lasts 8 cycles; release and sticky flag at e4+10, next launch at e4+11.
    pt(e4 + 9, 4'd8, 32'd0);
    pt(e4 + 10, 4'd8, 32'd1);
    sb_t.push_back(mk(16'd1004, 16'd1005, 16'd1006, 16'd1007, e4 + 11, 1'b1));
    pt(e4 + 30, 4'd8, 32'd1);
    pt(e4 + 30, 4'd7, 32'd1);
    wait_cyc(e4 + 32);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst_n = 1'b0; a_in = '0; a_vld = 1'b0; a_done = 1'b0;
    t_rst_n = 1'b0; t_in = '0; t_vld = 1'b0; t_done = 1'b0;
    @(negedge clk); @(negedge clk);
    pt(cyc + 1, 4'd0, 32'd1);
    for (int s = 1; s <= 6; s++) pt(cyc + 1, 4'(s), 32'd0);
    pt(cyc + 1, 4'd7, 32'd1);
    pt(cyc + 1, 4'd8, 32'd0);
    @(negedge clk);
    a_rst_n = 1'b1;
    t_rst_n = 1'b1;
    @(negedge clk);
    fork
      run_a();
      run_t();
    join
    repeat (4) @(negedge clk);
    end_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_buffer.md
# fft_frame_buffer

Upstream framing stage for the 4-point FFT core. Accepts a stream of signed 16-bit real samples over a valid/ready handshake and collects them into 4-sample frames in a ping-pong buffer. It presents each full frame as four packed complex words {real[31:16], imag[15:0]} with imaginary part zero, pulses `fft_start`, and waits for the core's `done` before releasing the bank. Collection of the next frame continues while the FFT is busy.

## Interface
- `SAMPLE_W`, 16: sample width; complex word width is 2*SAMPLE_W.
- `TIMEOUT_CYCLES`, 64: maximum cycles spent waiting for `fft_done`; 0 disables the timeout.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sample_in`  in  SAMPLE_W  signed real sample.
- `sample_valid`  in  1  `sample_in` is valid this cycle.
- `sample_ready`  out  1  buffer can accept a sample this cycle.
- `fft_in0`..`fft_in3`  out  2*SAMPLE_W each  frame words to the FFT, packed as {real, imag}.
- `fft_start`  out  1  one-cycle launch pulse to the FFT.
- `fft_done`  in  1  FFT completion, level; only the rising edge is used.
- `fft_timeout`  out  1  sticky flag: an FFT wait timed out.

## Operation
- Storage: two banks of 4 samples, `full[1:0]`, write bank pointer `wr_bank`, write index `wr_idx` (0..3), read bank pointer `rd_bank`.
- Accept rule: a sample is taken when `sample_valid && sample_ready`. `sample_ready = !full[wr_bank]`, combinational.
- On accept, the sample is stored at `bank[wr_bank][wr_idx]` and `wr_idx` increments.
  - When `wr_idx == 3`, `full[wr_bank]` is set, `wr_bank` toggles and `wr_idx` wraps to 0.
- Read FSM has three states: IDLE, START, BUSY.
  - IDLE -> START when `full[rd_bank]`. Latch `fft_in0..3 = {bank[rd_bank][k], 0}` and assert `fft_start`.
  - START -> BUSY unconditionally. Deassert `fft_start` and clear the timeout counter.
  - BUSY -> IDLE on a `fft_done` rising edge (`fft_done && !done_q`), or on timeout. In both cases clear `full[rd_bank]` and toggle `rd_bank`.
- Edge detection: `done_q` registers `fft_done` every cycle.
- `fft_in0..3` hold their value until the next launch.
- Timeout: the counter increments on every BUSY cycle. If it reaches `TIMEOUT_CYCLES-1` with no done edge, leave BUSY on that edge and set `fft_timeout`. `fft_timeout` is cleared only by reset.
- Same-cycle write completion into bank A and read release of bank B: both take effect; the paths are independent.
- A done edge seen in IDLE or START is ignored.
- Reset asserted (including mid-frame or mid-BUSY): the FSM goes to IDLE.
  - `full`, `wr_bank`, `rd_bank`, `wr_idx`, `done_q`, the counter and both banks clear.
  - Any partial frame is discarded.
  - Outputs: `fft_in0..3 = 0`, `fft_start = 0`, `fft_timeout = 0`, `sample_ready = 1`.

## Timing
- The 4th sample of a frame is accepted at edge N, and `full` is set at N.
- At edge N+1: IDLE->START, `fft_in*` update and `fft_start` goes high.
- At edge N+2: `fft_start` goes low; it is high for exactly 1 cycle.
- A done edge sampled at edge D releases the bank at D. The next frame can launch at edge D+1 (`fft_start` high after D+1) if that bank is full.
- Throughput: one frame per (2 + FFT latency + 1) cycles. The input stalls only when both banks are full.

## Configuration
- `FFT_WINDOW_EN`: when defined, each sample is windowed before storage with a periodic 4-point Hann window.
  - Index 0 -> 0, index 1 -> `x>>>1`, index 2 -> `x`, index 3 -> `x>>>1`.
  - `>>>` is an arithmetic shift that rounds toward negative infinity; no multiplier is used.
- Undefined: samples are stored unmodified.
- Handshake and timing are identical in both builds.

## Structure
- Shared package `fft_pkg` holds:
  - `SAMPLE_W`
  - `complex_t`, a packed struct {logic signed [15:0] re, im}
  - the FSM state enum `fb_state_t` (IDLE, START, BUSY)
- One sub-module, `fft_window_4`: combinational (sample, index) -> windowed sample. It is instantiated only under `FFT_WINDOW_EN`.

## Test plan
- Basic frame: samples 100, 200, 300, 400 back-to-back with `fft_done` returned 5 cycles after the launch.
  - Expect `fft_in0..3` = {100,0}, {200,0}, {300,0}, {400,0}.
  - Expect `fft_start` high for 1 cycle, at the edge after the 4th accept.
- Backpressure: 9 samples offered with `fft_done` held low and `TIMEOUT_CYCLES=0`.
  - Expect `sample_ready` low after the 8th accept; the 9th sample stalls.
  - On the first `fft_done` edge, `sample_ready` rises and the 9th is accepted.
  - The second frame launches 1 cycle after the release.
- Timeout: `TIMEOUT_CYCLES=8`, `fft_done` never asserted.
  - Expect BUSY to last 8 cycles, then `fft_timeout` = 1 (sticky) and the next full frame to launch.
- Stale done: `fft_done` held high across a launch.
  - Expect no release until `fft_done` falls and rises again.
- Window (with `FFT_WINDOW_EN`): inputs 100, 200, 300, 400.
  - Expect real parts 0, 100, 300, 200.
  - Input -3 at index 1 gives -2.
- Reset mid-BUSY with 2 samples pending: assert reset.
  - Expect all outputs 0, `sample_ready` = 1.
  - The next 4 samples form frame 0 in bank 0.
